// File: rtl/pwm_multi_deadtime.sv
// Multi-channel complementary PWM: shared prescaled period counter, double-buffered duty,
// per-channel dead-time insertion. Define PWM_CENTER_ALIGN_EN for up/down (centre-aligned) counting.
module pwm_multi_deadtime #(
  parameter int PWM_WIDTH  = 8,
  parameter int N_CH       = 2,
  parameter int PRESCALE   = 1,
  parameter int DEAD_TICKS = 2,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 duty_valid,
  input  logic [CH_W-1:0]      duty_ch,
  input  logic [PWM_WIDTH-1:0] duty_in,
  output logic                 duty_ready,
  output logic                 step,
  output logic [N_CH-1:0]      pwm_out,
  output logic [N_CH-1:0]      pwm_not_out
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DC_W  = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;

  localparam logic [PWM_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [DC_W-1:0]      DC_SAT   = DC_W'(DEAD_TICKS);

  typedef logic [PWM_WIDTH-1:0] duty_t;
  typedef logic [DC_W-1:0]      dead_t;

  logic [PRE_W-1:0] pre_q, pre_d;
  duty_t            cnt_q, cnt_d;
  logic             restart_q, restart_d;
  logic             step_q, step_d;
  duty_t [N_CH-1:0] shadow_q, shadow_d;
  duty_t [N_CH-1:0] active_q, active_d;
  logic  [N_CH-1:0] raw_q, raw_d;
  dead_t [N_CH-1:0] dc_q, dc_d;
  logic  [N_CH-1:0] pwm_q, pwm_d;
  logic  [N_CH-1:0] pwm_n_q, pwm_n_d;

  logic tick;
  logic period_start;
  logic wr_en;

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  dir_e dir_q, dir_d;
`endif

  // Timebase: prescaler, period counter and period-start detection.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    tick         = ena && (pre_q == PRE_LAST);
    pre_d        = pre_q;
    cnt_d        = cnt_q;
    restart_d    = restart_q;
    period_start = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d        = dir_q;
`endif
    if (!ena) begin
      pre_d     = '0;
      cnt_d     = '0;
      restart_d = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d     = DIR_UP;
`endif
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        restart_d = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        // Each endpoint is held for one extra tick while the direction flips.
        if (dir_q == DIR_UP) begin
          if (cnt_q == CNT_MAX) dir_d = DIR_DOWN;
          else                  cnt_d = cnt_q + 1'b1;
        end else begin
          if (cnt_q == '0) dir_d = DIR_UP;
          else             cnt_d = cnt_q - 1'b1;
        end
        period_start = restart_q || ((dir_q == DIR_DOWN) && (cnt_q == PWM_WIDTH'(1)));
`else
        cnt_d        = cnt_q + 1'b1;
        period_start = restart_q || (cnt_q == CNT_MAX);
`endif
      end
    end
    step_d = period_start;
  end

  // Duty buffering, compare and dead-time per channel.
  always_comb begin
    wr_en    = duty_valid && !step_q;
    shadow_d = shadow_q;
    active_d = active_q;
    raw_d    = '0;
    dc_d     = dc_q;
    pwm_d    = '0;
    pwm_n_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      // Out-of-range channel numbers match no slot, so the write completes but is dropped.
      if (wr_en && (duty_ch == CH_W'(i))) shadow_d[i] = duty_in;
      if (step_q) active_d[i] = shadow_q[i];
      raw_d[i] = ena && (cnt_q < active_q[i]);
      if (!ena || (raw_d[i] != raw_q[i])) dc_d[i] = '0;
      else if (dc_q[i] != DC_SAT)         dc_d[i] = dc_q[i] + 1'b1;
      pwm_d[i]   = ena &&  raw_q[i] && (dc_q[i] == DC_SAT);
      pwm_n_d[i] = ena && !raw_q[i] && (dc_q[i] == DC_SAT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      // Leaving reset behaves like ena rising: the first tick starts a period.
      restart_q <= 1'b1;
      step_q    <= 1'b0;
      // NOTE: the duty buffers are a handful of flops, not a RAM, so they are reset with everything else.
      shadow_q  <= '0;
      active_q  <= '0;
      raw_q     <= '0;
      dc_q      <= '0;
      pwm_q     <= '0;
      pwm_n_q   <= '0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q     <= DIR_UP;
`endif
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      restart_q <= restart_d;
      step_q    <= step_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      raw_q     <= raw_d;
      dc_q      <= dc_d;
      pwm_q     <= pwm_d;
      pwm_n_q   <= pwm_n_d;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q     <= dir_d;
`endif
    end
  end

  assign duty_ready  = !step_q;
  assign step        = step_q;
  assign pwm_out     = pwm_q;
  assign pwm_not_out = pwm_n_q;

endmodule
